// File: rtl/fpga_100hz_mon_pkg.sv
// Shared types and constants for the 100 Hz reference clock monitor.
package fpga_100hz_mon_pkg;

   localparam int unsigned PCNT_W = 18;
   localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED,
      FAULT
   } mon_state_e;

endpackage

// File: rtl/fpga_100hz_mon_if.sv
// Control/status bundle of the 100 Hz monitor; master = host side, slave = monitor.
interface fpga_100hz_mon_if #(
   parameter int unsigned TICK_W = 32
);
   import fpga_100hz_mon_pkg::*;

   logic              clk100hz_in;
   logic              tick_clr;
   logic              fault_clr;
   logic              tick_pulse;
   logic [TICK_W-1:0] tick_count;
   logic [PCNT_W-1:0] last_period;
   logic              locked;
   logic              fault;

   modport master (
      output clk100hz_in, tick_clr, fault_clr,
      input  tick_pulse, tick_count, last_period, locked, fault
   );

   modport slave (
      input  clk100hz_in, tick_clr, fault_clr,
      output tick_pulse, tick_count, last_period, locked, fault
   );

endinterface

// File: rtl/fpga_sync2.sv
// Reusable two-flop synchronizer with asynchronous active-high reset.
module fpga_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fpga_100hz_mon.sv
// Receive-side monitor for the 100 Hz reference: ticks, period measurement, lock/fault.
// Tick counter is built only when FPGA_100HZ_MON_TICKCNT_EN is defined.
module fpga_100hz_mon
   import fpga_100hz_mon_pkg::*;
#(
   parameter int unsigned CLK_PER_HALF = 125000,
   parameter int unsigned TOL          = 64,
   parameter int unsigned LOCK_CNT     = 2,
   parameter int unsigned TICK_W       = 32
) (
   input  logic            clk25mhz,
   input  logic            reset,
   fpga_100hz_mon_if.slave mon
);

   localparam int unsigned NOM_I = 2 * CLK_PER_HALF;
   localparam logic [PCNT_W-1:0] WIN_LO = PCNT_W'(NOM_I - TOL);
   localparam logic [PCNT_W-1:0] WIN_HI = PCNT_W'(NOM_I + TOL);
   localparam logic [PCNT_W-1:0] TOUT   = PCNT_W'(NOM_I + TOL + 1);

   logic              sync2;
   logic              sync3;
   logic [1:0]        warm;
   logic              tick_det;
   logic              tick_pulse_q;
   logic [PCNT_W-1:0] pcnt;
   logic [PCNT_W-1:0] last_period_q;
   logic              locked_q;
   logic              fault_q;
   logic              in_win;
   logic              tout;
   logic [3:0]        good_q;
   logic [3:0]        good_d;
   mon_state_e        state_q;
   mon_state_e        state_d;

   fpga_sync2 u_sync (
      .clk (clk25mhz),
      .rst (reset),
      .d   (mon.clk100hz_in),
      .q   (sync2)
   );

   // Edge detect stays blind until sync3 holds a real sample, so an input
   // already high at reset release is absorbed without a tick.
   always_ff @(posedge clk25mhz or posedge reset) begin
      if (reset) begin
         sync3 <= 1'b0;
         warm  <= '0;
      end else begin
         sync3 <= sync2;
         if (!(&warm)) warm <= warm + 2'd1;
      end
   end

   assign tick_det = sync2 & ~sync3 & (&warm);
   assign in_win   = (pcnt >= WIN_LO) && (pcnt <= WIN_HI);
   assign tout     = !tick_det && (pcnt == TOUT);

   always_ff @(posedge clk25mhz or posedge reset) begin
      if (reset) begin
         tick_pulse_q  <= 1'b0;
         pcnt          <= '0;
         last_period_q <= '0;
         locked_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         tick_pulse_q <= tick_det;
         if (tick_det)
            pcnt <= PCNT_W'(1);
         else if (pcnt != PCNT_MAX)
            pcnt <= pcnt + 1'b1;
         if (tick_det && (state_q != IDLE))
            last_period_q <= pcnt;
         locked_q <= (state_q == LOCKED);
         fault_q  <= (state_q == FAULT);
      end
   end

   always_ff @(posedge clk25mhz or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         good_q  <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      unique case (state_q)
         IDLE: begin
            if (tick_det) begin
               state_d = MEASURE;
               good_d  = '0;
            end
         end
         MEASURE: begin
            if (tick_det) begin
               if (in_win) begin
                  good_d = good_q + 4'd1;
                  if (good_q + 4'd1 == 4'(LOCK_CNT)) state_d = LOCKED;
               end else begin
                  good_d = '0;
               end
            end else if (tout) begin
               state_d = IDLE;
            end
         end
         LOCKED: begin
            if ((tick_det && !in_win) || tout) state_d = FAULT;
         end
         FAULT: begin
            if (mon.fault_clr) state_d = IDLE;
         end
      endcase
   end

   assign mon.tick_pulse  = tick_pulse_q;
   assign mon.last_period = last_period_q;
   assign mon.locked      = locked_q;
   assign mon.fault       = fault_q;

`ifdef FPGA_100HZ_MON_TICKCNT_EN
   logic [TICK_W-1:0] tick_count_q;

   always_ff @(posedge clk25mhz or posedge reset) begin
      if (reset)
         tick_count_q <= '0;
      else if (mon.tick_clr)
         tick_count_q <= '0;
      else if (tick_det)
         tick_count_q <= tick_count_q + 1'b1;
   end

   assign mon.tick_count = tick_count_q;
`else
   localparam logic [TICK_W-1:0] TICK_ZERO = '0;

   assign mon.tick_count = TICK_ZERO;
`endif

endmodule

// File: tb/tb_fpga_100hz_mon.sv
// Self-checking bench for fpga_100hz_mon with a scaled-down period (NOM = 80 cycles).
module tb_fpga_100hz_mon;

   localparam int unsigned CPH      = 40;
   localparam int unsigned TOL      = 4;
   localparam int unsigned LOCK_CNT = 2;
   localparam int unsigned TICK_W   = 4;
   localparam int NOM  = 2 * CPH;
   localparam int LO   = NOM - TOL;
   localparam int HI   = NOM + TOL;
   localparam int TOUT = HI + 1;

   logic clk25mhz = 1'b0;
   logic reset;

   always #20 clk25mhz = ~clk25mhz;

   fpga_100hz_mon_if #(.TICK_W(TICK_W)) mon_if ();

   fpga_100hz_mon #(
      .CLK_PER_HALF (CPH),
      .TOL          (TOL),
      .LOCK_CNT     (LOCK_CNT),
      .TICK_W       (TICK_W)
   ) dut (
      .clk25mhz (clk25mhz),
      .reset    (reset),
      .mon      (mon_if)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_seen = 0;

   // reference model: abstract status flags plus expected register contents
   bit m_meas, m_locked, m_fault;
   int m_good, m_last, m_cnt, m_pulses;

   always @(negedge clk25mhz) if (mon_if.tick_pulse === 1'b1) pulse_seen++;

   function automatic void model_reset();
      m_meas = 0; m_locked = 0; m_fault = 0;
      m_good = 0; m_last = 0; m_cnt = 0;
   endfunction

   // p = cycles since the previous input rising edge
   function automatic void model_tick(input int p);
      bit idle = !m_meas && !m_locked && !m_fault;
      bit win  = (p >= LO) && (p <= HI);
      if (!idle && !m_fault && p > TOUT) begin
         if (m_locked) begin m_locked = 0; m_fault = 1; end
         else begin m_meas = 0; idle = 1; end
      end
      if (!idle) m_last = p;
      if (idle) begin
         m_meas = 1; m_good = 0;
      end else if (m_meas) begin
         if (win) begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_meas = 0; m_locked = 1; end
         end else begin
            m_good = 0;
         end
      end else if (m_locked && !win) begin
         m_locked = 0; m_fault = 1;
      end
`ifdef FPGA_100HZ_MON_TICKCNT_EN
      m_cnt = (m_cnt + 1) % (1 << TICK_W);
`endif
      m_pulses++;
   endfunction

   // Called at a negedge: raise the input there and check the resulting tick.
   task automatic drive_edge(input int p, input bit clr_with_tick, input string tag);
      mon_if.clk100hz_in = 1'b1;
      model_tick(p);
      if (clr_with_tick) m_cnt = 0;
      repeat (2) @(posedge clk25mhz);
      if (clr_with_tick) begin @(negedge clk25mhz); mon_if.tick_clr = 1'b1; end
      @(posedge clk25mhz); #1;
      mon_if.tick_clr = 1'b0;
      n_checks++;
      if (mon_if.tick_pulse !== 1'b1) begin
         n_fail++; $display("FAIL %s tick_pulse: got %b want 1", tag, mon_if.tick_pulse);
      end
      n_checks++;
      if (mon_if.last_period !== 18'(m_last)) begin
         n_fail++; $display("FAIL %s last_period: got %0d want %0d", tag, mon_if.last_period, m_last);
      end
      n_checks++;
      if (mon_if.tick_count !== TICK_W'(m_cnt)) begin
         n_fail++; $display("FAIL %s tick_count: got %0d want %0d", tag, mon_if.tick_count, m_cnt);
      end
      @(posedge clk25mhz); #1;
      n_checks++;
      if (mon_if.tick_pulse !== 1'b0) begin
         n_fail++; $display("FAIL %s tick_pulse width: got %b want 0", tag, mon_if.tick_pulse);
      end
      n_checks++;
      if (mon_if.locked !== m_locked || mon_if.fault !== m_fault) begin
         n_fail++;
         $display("FAIL %s status: got locked=%b fault=%b want locked=%b fault=%b",
                  tag, mon_if.locked, mon_if.fault, m_locked, m_fault);
      end
      n_checks++;
      if (pulse_seen !== m_pulses) begin
         n_fail++; $display("FAIL %s pulse count: got %0d want %0d", tag, pulse_seen, m_pulses);
      end
   endtask

   // From the check point after drive_edge, move to the next rise p cycles after the last one.
   task automatic gap(input int p, input bit clr_fault);
      repeat (p / 2 - 3) @(negedge clk25mhz);
      mon_if.clk100hz_in = 1'b0;
      if (clr_fault) begin
         mon_if.fault_clr = 1'b1;
         @(negedge clk25mhz);
         mon_if.fault_clr = 1'b0;
         @(negedge clk25mhz);
         if (m_fault) begin m_fault = 0; m_meas = 0; m_good = 0; end
         n_checks++;
         if (mon_if.fault !== m_fault || mon_if.locked !== m_locked) begin
            n_fail++;
            $display("FAIL fault_clr status: got locked=%b fault=%b want locked=%b fault=%b",
                     mon_if.locked, mon_if.fault, m_locked, m_fault);
         end
         repeat (p - p / 2 - 2) @(negedge clk25mhz);
      end else begin
         repeat (p - p / 2) @(negedge clk25mhz);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mon_if.clk100hz_in = 1'b0;
      mon_if.tick_clr = 1'b0;
      mon_if.fault_clr = 1'b0;
      model_reset();
      m_pulses = 0;
      repeat (4) @(negedge clk25mhz);
      n_checks++;
      if (mon_if.tick_pulse !== 1'b0 || mon_if.tick_count !== '0 || mon_if.last_period !== '0 ||
          mon_if.locked !== 1'b0 || mon_if.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset values: got tp=%b cnt=%0d lp=%0d locked=%b fault=%b want all 0",
                  mon_if.tick_pulse, mon_if.tick_count, mon_if.last_period, mon_if.locked, mon_if.fault);
      end
      reset = 1'b0;
      repeat (6) @(negedge clk25mhz);
   endtask

   task automatic test_ideal();
      drive_edge(0, 0, "ideal first");
      for (int i = 0; i < 4; i++) begin
         gap(NOM, 0);
         drive_edge(NOM, 0, "ideal");
      end
      n_checks++;
      if (mon_if.locked !== 1'b1) begin
         n_fail++; $display("FAIL ideal lock: got %b want 1", mon_if.locked);
      end
   endtask

   task automatic test_fault_relock();
      gap(LO - 1, 0);
      drive_edge(LO - 1, 0, "short period fault");
      gap(NOM, 1);
      drive_edge(NOM, 0, "relock first");
      for (int i = 0; i < 2; i++) begin
         gap(NOM, 0);
         drive_edge(NOM, 0, "relock");
      end
      gap(NOM, 1);
      drive_edge(NOM, 0, "clr while locked");
   endtask

   task automatic test_measure_restart();
      gap(TOUT + 15, 0);
      drive_edge(TOUT + 15, 0, "long period fault");
      gap(NOM, 1);
      drive_edge(NOM, 0, "meas first");
      gap(NOM, 0);
      drive_edge(NOM, 0, "meas good1");
      gap(NOM - 10, 0);
      drive_edge(NOM - 10, 0, "meas short");
      gap(NOM, 0);
      drive_edge(NOM, 0, "meas good again");
      gap(NOM, 0);
      drive_edge(NOM, 0, "meas lock");
   endtask

   task automatic test_boundaries();
      gap(LO, 0);
      drive_edge(LO, 0, "window low edge");
      gap(HI, 0);
      drive_edge(HI, 0, "window high edge");
      gap(TOUT, 0);
      drive_edge(TOUT, 0, "window high+1");
      gap(NOM, 0);
      drive_edge(NOM, 0, "fault still counts");
   endtask

   task automatic test_random();
      int p;
      int sel;
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 65)      p = int'($urandom_range(LO, HI));
         else if (sel < 82) p = int'($urandom_range(LO - 10, LO - 1));
         else               p = int'($urandom_range(HI + 1, HI + 10));
         gap(p, m_fault && ($urandom_range(0, 1) == 1));
         drive_edge(p, $urandom_range(0, 9) == 0, "random");
      end
   endtask

   task automatic test_stop();
      for (int i = 0; i < 8 && !m_locked; i++) begin
         gap(NOM, m_fault);
         drive_edge(NOM, 0, "stop prep");
      end
      repeat (TOUT - 1) @(posedge clk25mhz);
      #1;
      n_checks++;
      if (mon_if.fault !== 1'b0 || mon_if.locked !== m_locked) begin
         n_fail++;
         $display("FAIL stop early: got locked=%b fault=%b want locked=%b fault=0",
                  mon_if.locked, mon_if.fault, m_locked);
      end
      @(posedge clk25mhz); #1;
      m_locked = 0; m_fault = 1;
      n_checks++;
      if (mon_if.fault !== 1'b1 || mon_if.locked !== 1'b0) begin
         n_fail++;
         $display("FAIL stop timeout: got locked=%b fault=%b want locked=0 fault=1",
                  mon_if.locked, mon_if.fault);
      end
      repeat (100) @(posedge clk25mhz);
      #1;
      n_checks++;
      if (mon_if.tick_count !== TICK_W'(m_cnt) || pulse_seen !== m_pulses) begin
         n_fail++;
         $display("FAIL stop frozen: got cnt=%0d pulses=%0d want cnt=%0d pulses=%0d",
                  mon_if.tick_count, pulse_seen, m_cnt, m_pulses);
      end
      @(negedge clk25mhz);
      mon_if.clk100hz_in = 1'b0;
      mon_if.fault_clr = 1'b1;
      @(negedge clk25mhz);
      mon_if.fault_clr = 1'b0;
      m_fault = 0; m_meas = 0; m_good = 0;
      repeat (10) @(negedge clk25mhz);
      drive_edge(0, 0, "after stop");
   endtask

   task automatic test_wrap();
      gap(NOM - 2, 0);
      mon_if.tick_clr = 1'b1;
      @(negedge clk25mhz);
      mon_if.tick_clr = 1'b0;
      m_cnt = 0;
      n_checks++;
      if (mon_if.tick_count !== '0) begin
         n_fail++; $display("FAIL tick_clr: got %0d want 0", mon_if.tick_count);
      end
      @(negedge clk25mhz);
      drive_edge(NOM, 0, "wrap");
      for (int i = 0; i < 16; i++) begin
         gap(NOM, 0);
         drive_edge(NOM, 0, "wrap");
      end
      gap(NOM, 0);
      drive_edge(NOM, 1, "clr with tick");
   endtask

   task automatic test_reset_high();
      @(negedge clk25mhz);
      reset = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (mon_if.tick_pulse !== 1'b0 || mon_if.tick_count !== '0 || mon_if.last_period !== '0 ||
          mon_if.locked !== 1'b0 || mon_if.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL async reset: got tp=%b cnt=%0d lp=%0d locked=%b fault=%b want all 0",
                  mon_if.tick_pulse, mon_if.tick_count, mon_if.last_period, mon_if.locked, mon_if.fault);
      end
      repeat (3) @(negedge clk25mhz);
      reset = 1'b0;
      repeat (20) @(negedge clk25mhz);
      n_checks++;
      if (pulse_seen !== m_pulses) begin
         n_fail++; $display("FAIL no tick after reset: got %0d pulses want %0d", pulse_seen, m_pulses);
      end
      mon_if.clk100hz_in = 1'b0;
      repeat (10) @(negedge clk25mhz);
      drive_edge(0, 0, "post reset first");
      gap(NOM, 0);
      drive_edge(NOM, 0, "post reset second");
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_fault_relock();
      test_measure_restart();
      test_boundaries();
      test_random();
      test_stop();
      test_wrap();
      test_reset_high();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/fpga_100hz_mon.md
# fpga_100hz_mon

Receive-side monitor for the 100 Hz reference clock produced by the board's 100 Hz generator. It samples the slow clock in the 25 MHz domain, emits one-cycle ticks on each rising edge, measures each period, and reports lock/fault status. Benchmark software reads it as a free-running 10 ms tick counter, so it sits beside the generator in the FPGA system layer.

## Interface
- `CLK_PER_HALF`, 125000: nominal clk25mhz cycles per half period; nominal period NOM = 2*CLK_PER_HALF.
- `TOL`, 64: allowed deviation of a measured period from NOM, in cycles.
- `LOCK_CNT`, 2: consecutive in-window periods required to lock (1..15).
- `TICK_W`, 32: tick counter width.
- `clk25mhz`  in  1  sole clock, 25 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `clk100hz_in`  in  1  100 Hz clock under monitor; asynchronous to clk25mhz.
- `tick_clr`  in  1  synchronous clear of tick_count.
- `fault_clr`  in  1  synchronous clear of sticky fault; re-arms the monitor.
- `tick_pulse`  out  1  one-cycle pulse per detected rising edge.
- `tick_count`  out  TICK_W  rising edges seen since reset/clear.
- `last_period`  out  18  most recent measured period in clk25mhz cycles.
- `locked`  out  1  period stable within window.
- `fault`  out  1  sticky: period out of window or clock lost while locked.

## Operation
- Input path: 2-flop synchronizer, then a third flop; edge = sync2 & ~sync3, registered into tick_pulse.
- Period counter pcnt, 18 bits: loads 1 on each tick_pulse, otherwise increments, saturating at 2^18-1. On a tick_pulse (other than the first after IDLE), last_period <= pcnt.
- In-window: NOM-TOL <= pcnt <= NOM+TOL. Timeout: pcnt == NOM+TOL+1 with no edge.
- FSM states IDLE, MEASURE, LOCKED, FAULT:
  - IDLE: first tick -> MEASURE, good count cleared.
  - MEASURE: in-window tick -> good+1; at good==LOCK_CNT -> LOCKED. Out-of-window tick -> good cleared, remain MEASURE (this edge restarts measurement). Timeout -> IDLE.
  - LOCKED: in-window tick stays. Out-of-window tick or timeout -> FAULT.
  - FAULT: ticks still counted and last_period still updated; only fault_clr leaves, -> IDLE.
- locked = (state==LOCKED), fault = (state==FAULT); both registered.
- tick_count increments on every tick_pulse in all states, wraps modulo 2^TICK_W. tick_clr together with a tick: result 0 (clear wins).
- fault_clr outside FAULT: no effect. fault_clr in the same cycle as a LOCKED->FAULT event: transition to FAULT occurs; clear is lost.

## Timing
- Reset values: tick_pulse 0, tick_count 0, last_period 0, locked 0, fault 0, state IDLE, pcnt 0, synchronizer flops 0.
- tick_pulse high on the 3rd clk25mhz edge after the first edge sampling clk100hz_in high (±1 cycle synchronizer uncertainty).
- last_period and state update in the same cycle tick_pulse is high; locked/fault visible the following cycle.
- Reset mid-operation: all state returns to reset values immediately; an input already high at reset release produces no tick (sync3 catches up without edge).

## Configuration
- `FPGA_100HZ_MON_TICKCNT_EN` defined: tick_count and tick_clr function as described.
- Undefined: counter not built, tick_count tied to 0, tick_clr ignored; tick_pulse, period measurement and FSM unchanged.

## Structure
- Package `fpga_100hz_mon_pkg`: state enum (IDLE, MEASURE, LOCKED, FAULT), PCNT_W = 18, PCNT_MAX constant.
- Derived NOM/window bounds computed locally from parameters.
- Sub-module `fpga_sync2`: reusable 2-flop synchronizer with asynchronous active-high reset.

## Test plan
- Ideal 100 Hz input (period 250000) -> tick_pulse once per 250000 cycles, last_period = 250000, locked rises one cycle after 3rd tick, fault 0.
- Locked, one period of 250100 -> fault = 1, locked = 0 next cycle; fault_clr -> IDLE, relocks after 3 further good ticks.
- Locked, input stops -> fault asserts when pcnt reaches 250065; tick_count frozen.
- MEASURE with period 249900 then good periods -> good count resets, locked only after 2 consecutive 250000 periods.
- tick_count at 2^32-1 plus one tick -> 0; tick_clr coincident with tick -> 0.
- Reset asserted mid-period with input high -> all outputs 0; release with input high -> no tick until next rising edge.
